// File: rtl/mem_bus_arbiter.sv
// Purpose: arbitrates the I-cache and D-cache/LSQ onto one tagged memory port and steers each returning load to the requester that issued it.
// Latency: the grant, forwarding and return routing are combinational. The owner table and pending_loads update at the next clock edge.
// Backpressure: the loser, or a rejected winner, sees a zero response and must hold its command. `ifdef MEM_ARB_STARVE_GUARD_EN adds a forced grant for I.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2Imem_command,
    input  logic [31:0] proc2Imem_addr,
    output logic [3:0]  Imem2proc_response,
    output logic [63:0] Imem2proc_data,
    output logic [3:0]  Imem2proc_tag,
    input  logic [1:0]  proc2Dmem_command,
    input  logic [31:0] proc2Dmem_addr,
    input  logic [63:0] proc2Dmem_data,
    output logic [3:0]  Dmem2proc_response,
    output logic [63:0] Dmem2proc_data,
    output logic [3:0]  Dmem2proc_tag,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,
    output logic [4:0]  pending_loads,
    output logic        spurious_tag
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic        i_req;
    logic        d_req;
    logic        force_i;
    logic        grant_i;
    logic        grant_d;
    logic        accepted;
    logic [1:0]  win_command;
    logic        set_en;
    logic        ret_tag_nz;
    logic        ret_hit;
    logic        ret_owner;
    logic [15:0] tag_valid;
    logic [15:0] tag_owner;
    logic [15:0] valid_next;
    logic [15:0] owner_next;

    assign i_req    = (proc2Imem_command != BUS_NONE);
    assign d_req    = (proc2Dmem_command != BUS_NONE);
    assign accepted = (mem2proc_response != 4'd0);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // Once I has waited STARVE_LIMIT cycles it takes the port over D.
    assign force_i = i_req && (starve_cnt >= CNT_LIMIT);

    // Count I's denied cycles. Clear the count once I is actually accepted.
    // A rejected grant to I holds the count, so the forced grant is retried.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_i && accepted) begin
            starve_cnt <= '0;
        end else if (i_req && !grant_i && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_starve_limit;

    assign force_i             = 1'b0;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

    // D wins by default. I wins when D is idle, or when I's wait limit forces a grant.
    always_comb begin
        grant_d = d_req && !force_i;
        grant_i = i_req && !grant_d;
    end

    // Forward the winner to memory. Address defaults to I when nobody requests.
    always_comb begin
        win_command = BUS_NONE;
        if (grant_d) begin
            win_command = proc2Dmem_command;
        end else if (grant_i) begin
            win_command = proc2Imem_command;
        end
        proc2mem_command = reset ? BUS_NONE : win_command;
        proc2mem_addr    = grant_d ? proc2Dmem_addr : proc2Imem_addr;
        proc2mem_data    = grant_d ? proc2Dmem_data : 64'd0;
    end

    // Only the winner sees memory's acceptance tag.
    always_comb begin
        Imem2proc_response = (!reset && grant_i) ? mem2proc_response : 4'd0;
        Dmem2proc_response = (!reset && grant_d) ? mem2proc_response : 4'd0;
    end

    // Steer a return to the recorded owner. A return on an invalid entry is dropped and flagged.
    always_comb begin
        ret_tag_nz     = (mem2proc_tag != 4'd0);
        ret_hit        = ret_tag_nz && tag_valid[mem2proc_tag];
        ret_owner      = tag_owner[mem2proc_tag];
        Imem2proc_tag  = (!reset && ret_hit && !ret_owner) ? mem2proc_tag : 4'd0;
        Dmem2proc_tag  = (!reset && ret_hit && ret_owner)  ? mem2proc_tag : 4'd0;
        Imem2proc_data = mem2proc_data;
        Dmem2proc_data = mem2proc_data;
        spurious_tag   = !reset && ret_tag_nz && !tag_valid[mem2proc_tag];
    end

    // Next table state.
    // Clear the entry for a return, then apply the new load's set, so reuse of the same tag keeps the entry valid.
    always_comb begin
        set_en     = !reset && (win_command == BUS_LOAD) && accepted;
        valid_next = tag_valid;
        owner_next = tag_owner;
        if (ret_hit) begin
            valid_next[mem2proc_tag] = 1'b0;
        end
        if (set_en) begin
            valid_next[mem2proc_response] = 1'b1;
            owner_next[mem2proc_response] = grant_d;
        end
    end

    function automatic logic [4:0] count_valid(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int k = 0; k < 16; k++) begin
            n = n + {4'd0, v[k]};
        end
        return n;
    endfunction

    // Commit the owner table. Keep the outstanding-load count in step with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid     <= 16'd0;
            tag_owner     <= 16'd0;
            pending_loads <= 5'd0;
        end else begin
            tag_valid     <= valid_next;
            tag_owner     <= owner_next;
            pending_loads <= count_valid(valid_next);
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter, driven with directed vectors and hand-computed expected values.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
// Build with MEM_ARB_STARVE_GUARD_EN defined to exercise the forced grant for I.
module tb_mem_bus_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  proc2Imem_command;
    logic [31:0] proc2Imem_addr;
    logic [3:0]  Imem2proc_response;
    logic [63:0] Imem2proc_data;
    logic [3:0]  Imem2proc_tag;
    logic [1:0]  proc2Dmem_command;
    logic [31:0] proc2Dmem_addr;
    logic [63:0] proc2Dmem_data;
    logic [3:0]  Dmem2proc_response;
    logic [63:0] Dmem2proc_data;
    logic [3:0]  Dmem2proc_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [4:0]  pending_loads;
    logic        spurious_tag;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .proc2Imem_command(proc2Imem_command), .proc2Imem_addr(proc2Imem_addr),
        .Imem2proc_response(Imem2proc_response), .Imem2proc_data(Imem2proc_data),
        .Imem2proc_tag(Imem2proc_tag),
        .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
        .proc2Dmem_data(proc2Dmem_data),
        .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data),
        .Dmem2proc_tag(Dmem2proc_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag),
        .pending_loads(pending_loads), .spurious_tag(spurious_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        proc2Imem_command = 2'd0;
        proc2Imem_addr    = 32'd0;
        proc2Dmem_command = 2'd0;
        proc2Dmem_addr    = 32'd0;
        proc2Dmem_data    = 64'd0;
        mem2proc_response = 4'd0;
        mem2proc_data     = 64'd0;
        mem2proc_tag      = 4'd0;
    endtask

    task automatic test_reset;
        idle();
        reset             = 1'b1;
        proc2Imem_command = 2'd1;
        proc2Imem_addr    = 32'h0000_0800;
        mem2proc_response = 4'd2;
        mem2proc_tag      = 4'd2;
        @(negedge clock);
        checks++; if (proc2mem_command !== 2'd0) begin errors++; $display("FAIL reset_cmd: got %0d want 0", proc2mem_command); end
        checks++; if (Imem2proc_response !== 4'd0) begin errors++; $display("FAIL reset_iresp: got %0d want 0", Imem2proc_response); end
        checks++; if (Imem2proc_tag !== 4'd0 || Dmem2proc_tag !== 4'd0) begin errors++; $display("FAIL reset_tags: got I=%0d D=%0d want 0", Imem2proc_tag, Dmem2proc_tag); end
        checks++; if (spurious_tag !== 1'b0) begin errors++; $display("FAIL reset_spurious: got %b want 0", spurious_tag); end
        tick();
        tick();
        idle();
        reset = 1'b0;
        @(negedge clock);
        checks++; if (pending_loads !== 5'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", pending_loads); end
        tick();
    endtask

    task automatic test_lone_i_load;
        proc2Imem_command = 2'd1;
        proc2Imem_addr    = 32'h0000_1000;
        mem2proc_response = 4'd3;
        @(negedge clock);
        checks++; if (Imem2proc_response !== 4'd3) begin errors++; $display("FAIL lone_iresp: got %0d want 3", Imem2proc_response); end
        checks++; if (Dmem2proc_response !== 4'd0) begin errors++; $display("FAIL lone_dresp: got %0d want 0", Dmem2proc_response); end
        checks++; if (proc2mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL lone_addr: got %h want 00001000", proc2mem_addr); end
        checks++; if (proc2mem_command !== 2'd1) begin errors++; $display("FAIL lone_cmd: got %0d want 1", proc2mem_command); end
        tick();
        idle();
        checks++; if (pending_loads !== 5'd1) begin errors++; $display("FAIL lone_pending1: got %0d want 1", pending_loads); end
        mem2proc_tag  = 4'd3;
        mem2proc_data = 64'hDEAD_BEEF_0000_0001;
        @(negedge clock);
        checks++; if (Imem2proc_tag !== 4'd3) begin errors++; $display("FAIL lone_itag: got %0d want 3", Imem2proc_tag); end
        checks++; if (Imem2proc_data !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL lone_idata: got %h want deadbeef00000001", Imem2proc_data); end
        checks++; if (Dmem2proc_tag !== 4'd0) begin errors++; $display("FAIL lone_dtag: got %0d want 0", Dmem2proc_tag); end
        tick();
        idle();
        checks++; if (pending_loads !== 5'd0) begin errors++; $display("FAIL lone_pending0: got %0d want 0", pending_loads); end
    endtask

    task automatic test_priority;
        proc2Imem_command = 2'd1;
        proc2Imem_addr    = 32'h0000_2000;
        proc2Dmem_command = 2'd1;
        proc2Dmem_addr    = 32'h0000_3000;
        mem2proc_response = 4'd5;
        @(negedge clock);
        checks++; if (Dmem2proc_response !== 4'd5) begin errors++; $display("FAIL prio_dresp: got %0d want 5", Dmem2proc_response); end
        checks++; if (Imem2proc_response !== 4'd0) begin errors++; $display("FAIL prio_iresp: got %0d want 0", Imem2proc_response); end
        checks++; if (proc2mem_addr !== 32'h0000_3000) begin errors++; $display("FAIL prio_addr: got %h want 00003000", proc2mem_addr); end
        tick();
        proc2Dmem_command = 2'd0;
        mem2proc_response = 4'd6;
        @(negedge clock);
        checks++; if (Imem2proc_response !== 4'd6) begin errors++; $display("FAIL prio_iresp2: got %0d want 6", Imem2proc_response); end
        checks++; if (Dmem2proc_response !== 4'd0) begin errors++; $display("FAIL prio_dresp2: got %0d want 0", Dmem2proc_response); end
        checks++; if (proc2mem_addr !== 32'h0000_2000) begin errors++; $display("FAIL prio_addr2: got %h want 00002000", proc2mem_addr); end
        tick();
        idle();
        checks++; if (pending_loads !== 5'd2) begin errors++; $display("FAIL prio_pending2: got %0d want 2", pending_loads); end
        mem2proc_tag  = 4'd6;
        mem2proc_data = 64'h0000_0000_0000_0066;
        @(negedge clock);
        checks++; if (Imem2proc_tag !== 4'd6 || Dmem2proc_tag !== 4'd0) begin errors++; $display("FAIL prio_ret6: got I=%0d D=%0d want I=6 D=0", Imem2proc_tag, Dmem2proc_tag); end
        tick();
        mem2proc_tag  = 4'd5;
        mem2proc_data = 64'h0000_0000_0000_0055;
        @(negedge clock);
        checks++; if (Dmem2proc_tag !== 4'd5 || Imem2proc_tag !== 4'd0) begin errors++; $display("FAIL prio_ret5: got I=%0d D=%0d want I=0 D=5", Imem2proc_tag, Dmem2proc_tag); end
        checks++; if (Dmem2proc_data !== 64'h0000_0000_0000_0055) begin errors++; $display("FAIL prio_ddata: got %h want 55", Dmem2proc_data); end
        tick();
        idle();
        checks++; if (pending_loads !== 5'd0) begin errors++; $display("FAIL prio_pending0: got %0d want 0", pending_loads); end
    endtask

    task automatic test_store;
        proc2Dmem_command = 2'd2;
        proc2Dmem_addr    = 32'h0000_4000;
        proc2Dmem_data    = 64'h0000_0000_0000_1234;
        mem2proc_response = 4'd7;
        @(negedge clock);
        checks++; if (Dmem2proc_response !== 4'd7) begin errors++; $display("FAIL store_dresp: got %0d want 7", Dmem2proc_response); end
        checks++; if (proc2mem_command !== 2'd2) begin errors++; $display("FAIL store_cmd: got %0d want 2", proc2mem_command); end
        checks++; if (proc2mem_data !== 64'h0000_0000_0000_1234) begin errors++; $display("FAIL store_data: got %h want 1234", proc2mem_data); end
        tick();
        idle();
        checks++; if (pending_loads !== 5'd0) begin errors++; $display("FAIL store_pending: got %0d want 0", pending_loads); end
        mem2proc_tag = 4'd7;
        @(negedge clock);
        checks++; if (spurious_tag !== 1'b1) begin errors++; $display("FAIL store_spurious: got %b want 1", spurious_tag); end
        checks++; if (Imem2proc_tag !== 4'd0 || Dmem2proc_tag !== 4'd0) begin errors++; $display("FAIL store_tags: got I=%0d D=%0d want 0", Imem2proc_tag, Dmem2proc_tag); end
        tick();
        idle();
        @(negedge clock);
        checks++; if (spurious_tag !== 1'b0) begin errors++; $display("FAIL store_spurious_clr: got %b want 0", spurious_tag); end
        tick();
    endtask

    task automatic test_tag_reuse;
        proc2Imem_command = 2'd1;
        proc2Imem_addr    = 32'h0000_5000;
        mem2proc_response = 4'd4;
        tick();
        idle();
        checks++; if (pending_loads !== 5'd1) begin errors++; $display("FAIL reuse_pending1: got %0d want 1", pending_loads); end
        mem2proc_tag      = 4'd4;
        proc2Dmem_command = 2'd1;
        proc2Dmem_addr    = 32'h0000_6000;
        mem2proc_response = 4'd4;
        @(negedge clock);
        checks++; if (Imem2proc_tag !== 4'd4 || Dmem2proc_tag !== 4'd0) begin errors++; $display("FAIL reuse_ret_old: got I=%0d D=%0d want I=4 D=0", Imem2proc_tag, Dmem2proc_tag); end
        checks++; if (Dmem2proc_response !== 4'd4) begin errors++; $display("FAIL reuse_dresp: got %0d want 4", Dmem2proc_response); end
        tick();
        idle();
        checks++; if (pending_loads !== 5'd1) begin errors++; $display("FAIL reuse_pending_keep: got %0d want 1", pending_loads); end
        mem2proc_tag = 4'd4;
        @(negedge clock);
        checks++; if (Dmem2proc_tag !== 4'd4 || Imem2proc_tag !== 4'd0) begin errors++; $display("FAIL reuse_ret_new: got I=%0d D=%0d want I=0 D=4", Imem2proc_tag, Dmem2proc_tag); end
        tick();
        idle();
        checks++; if (pending_loads !== 5'd0) begin errors++; $display("FAIL reuse_pending0: got %0d want 0", pending_loads); end
    endtask

    task automatic test_reset_midop;
        proc2Imem_command = 2'd1;
        proc2Imem_addr    = 32'h0000_7000;
        mem2proc_response = 4'd1;
        tick();
        idle();
        proc2Dmem_command = 2'd1;
        proc2Dmem_addr    = 32'h0000_7008;
        mem2proc_response = 4'd2;
        tick();
        idle();
        checks++; if (pending_loads !== 5'd2) begin errors++; $display("FAIL midop_pending2: got %0d want 2", pending_loads); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (pending_loads !== 5'd0) begin errors++; $display("FAIL midop_pending0: got %0d want 0", pending_loads); end
        mem2proc_tag = 4'd1;
        @(negedge clock);
        checks++; if (spurious_tag !== 1'b1) begin errors++; $display("FAIL midop_spurious: got %b want 1", spurious_tag); end
        checks++; if (Imem2proc_tag !== 4'd0) begin errors++; $display("FAIL midop_itag: got %0d want 0", Imem2proc_tag); end
        tick();
        idle();
    endtask

    task automatic test_starve;
        proc2Imem_command = 2'd1;
        proc2Imem_addr    = 32'h0000_8000;
        proc2Dmem_command = 2'd1;
        proc2Dmem_addr    = 32'h0000_9000;
        mem2proc_response = 4'd0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            checks++; if (proc2mem_addr !== 32'h0000_9000) begin errors++; $display("FAIL starve_early_c%0d: got %h want 00009000", c, proc2mem_addr); end
            tick();
        end
        mem2proc_response = 4'd9;
        @(negedge clock);
`ifdef MEM_ARB_STARVE_GUARD_EN
        checks++; if (proc2mem_addr !== 32'h0000_8000) begin errors++; $display("FAIL starve_force_addr: got %h want 00008000", proc2mem_addr); end
        checks++; if (Imem2proc_response !== 4'd9 || Dmem2proc_response !== 4'd0) begin errors++; $display("FAIL starve_force_resp: got I=%0d D=%0d want I=9 D=0", Imem2proc_response, Dmem2proc_response); end
`else
        checks++; if (proc2mem_addr !== 32'h0000_9000) begin errors++; $display("FAIL starve_strict_addr: got %h want 00009000", proc2mem_addr); end
        checks++; if (Dmem2proc_response !== 4'd9 || Imem2proc_response !== 4'd0) begin errors++; $display("FAIL starve_strict_resp: got I=%0d D=%0d want I=0 D=9", Imem2proc_response, Dmem2proc_response); end
`endif
        tick();
        idle();
        checks++; if (pending_loads !== 5'd1) begin errors++; $display("FAIL starve_pending: got %0d want 1", pending_loads); end
        mem2proc_tag = 4'd9;
        @(negedge clock);
`ifdef MEM_ARB_STARVE_GUARD_EN
        checks++; if (Imem2proc_tag !== 4'd9 || Dmem2proc_tag !== 4'd0) begin errors++; $display("FAIL starve_ret: got I=%0d D=%0d want I=9 D=0", Imem2proc_tag, Dmem2proc_tag); end
`else
        checks++; if (Dmem2proc_tag !== 4'd9 || Imem2proc_tag !== 4'd0) begin errors++; $display("FAIL starve_ret: got I=%0d D=%0d want I=0 D=9", Imem2proc_tag, Dmem2proc_tag); end
`endif
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        test_reset();
        test_lone_i_load();
        test_priority();
        test_store();
        test_tag_reuse();
        test_reset_midop();
        test_starve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single tagged memory port between the instruction cache controller (requester I) and the data cache/LSQ (requester D).
- Picks one requester per cycle and forwards its command/address/data to memory.
- Passes the memory acceptance tag back to the winner only.
- Records tag ownership so that later data returns (mem2proc_tag) are steered to the requester that issued the load.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles requester I may be denied before forced grant (used only with the optional feature).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- proc2Imem_command  input  2  I request: BUS_NONE/BUS_LOAD (BUS_STORE never issued by I)
- proc2Imem_addr  input  32  I request address, 8-byte aligned
- Imem2proc_response  output  4  acceptance tag to I; 0 = not accepted
- Imem2proc_data  output  64  returned data to I
- Imem2proc_tag  output  4  data-return tag to I; 0 = no return this cycle
- proc2Dmem_command  input  2  D request: BUS_NONE/BUS_LOAD/BUS_STORE
- proc2Dmem_addr  input  32  D request address
- proc2Dmem_data  input  64  D store data
- Dmem2proc_response  output  4  acceptance tag to D
- Dmem2proc_data  output  64  returned data to D
- Dmem2proc_tag  output  4  data-return tag to D
- proc2mem_command  output  2  command to memory
- proc2mem_addr  output  32  address to memory
- proc2mem_data  output  64  store data to memory
- mem2proc_response  input  4  memory acceptance tag; 0 = rejected
- mem2proc_data  input  64  memory return data
- mem2proc_tag  input  4  memory return tag; 0 = none
- pending_loads  output  5  number of valid owner-table entries (0..15)
- spurious_tag  output  1  one-cycle pulse: nonzero mem2proc_tag with no valid owner

Behaviour:
- Grant is combinational, in the same cycle as the request.
  - Requesters hold their command until they see a nonzero response.
  - Default priority: D over I; I is granted only when proc2Dmem_command == BUS_NONE.
- Forwarding and response routing:
  - Winner's command/addr/data are forwarded to memory.
  - If no request, proc2mem_command = BUS_NONE; addr and data are don't-care but driven from I.
  - mem2proc_response goes to the winner's *_response; the loser sees 0.
  - No winner: both responses are 0.
- Owner table: 16 entries (index 1..15 usable; entry 0 unused), each holding valid + owner bit (0 = I, 1 = D).
  - Set: on a granted BUS_LOAD with mem2proc_response != 0, entry[mem2proc_response] <= {valid = 1, owner = winner} at the clock edge.
  - Granted BUS_STORE records nothing.
- Return routing (combinational):
  - If mem2proc_tag != 0 and entry[mem2proc_tag].valid, drive owner's *_tag = mem2proc_tag and *_data = mem2proc_data.
  - The non-owner's tag is 0.
  - The entry is cleared at the clock edge.
  - Both *_data outputs may always carry mem2proc_data; only *_tag qualifies it.
- Spurious return: mem2proc_tag != 0 with the entry invalid.
  - Both tags are 0 and the data is dropped.
  - spurious_tag = 1 for that cycle.
- Simultaneous return and reissue of the same tag T in one cycle:
  - The return is routed to the old owner.
  - Set beats clear: entry[T] ends valid with the new owner.
- pending_loads: popcount of valid bits, registered in step with the table.
- Reset (synchronous):
  - All table entries are invalidated; pending_loads = 0.
  - While reset is high: proc2mem_command = BUS_NONE, both *_response = 0, both *_tag = 0, spurious_tag = 0.
  - Reset mid-operation: outstanding returns arriving after reset deassertion are treated as spurious (dropped, spurious_tag pulses).

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- With it defined:
  - A 3-bit-minimum saturating counter increments each cycle I requests but is not granted.
  - The counter clears on an I grant or on reset.
  - When counter >= STARVE_LIMIT, I wins over D for that cycle; a rejected forced grant keeps the counter unchanged.
- Without it: strict D priority; no counter logic exists.

Test Plan:
- Lone I load at 0x0000_1000, mem2proc_response = 3 -> Imem2proc_response = 3, Dmem2proc_response = 0, proc2mem_addr = 0x1000, BUS_LOAD; pending_loads = 1. Later mem2proc_tag = 3 with data 0xDEAD_BEEF_0000_0001 -> Imem2proc_tag = 3 with that data, Dmem2proc_tag = 0; pending_loads = 0.
- I and D load in the same cycle, response = 5 -> D gets 5, I gets 0, proc2mem_addr = D addr. Next cycle D idle -> I granted with response = 6. Tags 5 and 6 return in reverse order -> routed to D and I respectively.
- D BUS_STORE with data 0x1234, response = 7 -> Dmem2proc_response = 7, no table entry, pending_loads unchanged. A later mem2proc_tag = 7 -> spurious_tag = 1, both tags 0.
- Tag 4 returns (owner I) in the same cycle D load is accepted with response = 4 -> Imem2proc_tag = 4 this cycle. Next cycle entry 4 is valid with owner D; a later return of tag 4 goes to D.
- Issue loads on tags 1 and 2, then pulse reset for 1 cycle -> pending_loads = 0, and a return of tag 1 afterwards -> spurious_tag = 1. Repeat with D held busy and MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT = 4 -> I granted on its 5th requesting cycle.
